// File: rtl/board_io_ctrl.sv
// board_io_ctrl: Avalon-MM board I/O controller.
// Drives NUM_LEDS LEDs, each off, on, blinking or PWM-dimmed. Conditions NUM_KEYS
// active-low push-buttons with a synchroniser, a debouncer, press-edge capture and a
// maskable level interrupt.
// Optional feature macro: BOARD_IO_PWM_EN. When it is undefined, the PWM counter and the
// duty register are not built, mode 11 lights the LED steadily, and address 4 reads 0.
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   avs_address    word address (0 KEY_STATE, 1 KEY_EDGE, 2 KEY_MASK, 3 LED_MODE,
//                  4 PWM_DUTY, 5 BLINK_PERIOD)
//   avs_read       read strobe; avs_readdata is valid one cycle later
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data, holds its value while avs_read is low
//   irq            registered level interrupt, |(KEY_EDGE & KEY_MASK)
//   key_n          raw buttons, low = pressed, asynchronous
//   led            registered LED drive, high = lit
module board_io_ctrl #(
   parameter int unsigned NUM_LEDS        = 4,
   parameter int unsigned NUM_KEYS        = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 2000000,
   parameter int unsigned PWM_BITS        = 8,
   parameter int unsigned BLINK_DIV_BITS  = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          avs_address,
   input  logic                avs_read,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   output logic [31:0]         avs_readdata,
   output logic                irq,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_LEDS-1:0] led
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0]       sync1_q, sync2_q;
   logic [NUM_KEYS-1:0]       state_q, state_d;
   logic [NUM_KEYS-1:0]       key_edge_q, key_edge_d;
   logic [NUM_KEYS-1:0]       mask_q, mask_d;
   logic [NUM_KEYS-1:0]       press, edge_clr;
   logic [CntW-1:0]           cnt_q [NUM_KEYS];
   logic [CntW-1:0]           cnt_d [NUM_KEYS];
   logic [2*NUM_LEDS-1:0]     mode_q, mode_d;
   logic [BLINK_DIV_BITS-1:0] period_q, period_d;
   logic [BLINK_DIV_BITS-1:0] blink_cnt_q, blink_cnt_d;
   logic                      phase_q, phase_d;
   logic [NUM_LEDS-1:0]       led_q, led_d;
   logic                      irq_q, irq_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      pwm_lit;
   logic                      unused_wdata;

   // Keeps the unused upper write-data bits from being flagged.
   assign unused_wdata = ^avs_writedata;

`ifdef BOARD_IO_PWM_EN
   localparam logic [PWM_BITS-1:0] DutyRst = PWM_BITS'(1) << (PWM_BITS - 1);
   logic [PWM_BITS-1:0] pwm_cnt_q, duty_q, duty_d;

   always_comb begin
      duty_d = duty_q;
      if (avs_write && avs_address == 3'd4) duty_d = avs_writedata[PWM_BITS-1:0];
   end

   assign pwm_lit = (pwm_cnt_q < duty_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_q <= '0;
         duty_q    <= DutyRst;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         duty_q    <= duty_d;
      end
   end
`else
   assign pwm_lit = 1'b1;
`endif

   // Debounce: count while the synchronised level disagrees with the accepted state;
   // flip once it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      state_d = state_q;
      press   = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         cnt_d[i] = '0;
         if (~sync2_q[i] != state_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               state_d[i] = ~state_q[i];
               press[i]   = ~state_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      edge_clr = '0;
      mask_d   = mask_q;
      mode_d   = mode_q;
      period_d = period_q;
      if (avs_write) begin
         case (avs_address)
            3'd1:    edge_clr = avs_writedata[NUM_KEYS-1:0];
            3'd2:    mask_d   = avs_writedata[NUM_KEYS-1:0];
            3'd3:    mode_d   = avs_writedata[2*NUM_LEDS-1:0];
            3'd5:    period_d = avs_writedata[BLINK_DIV_BITS-1:0];
            default: ;
         endcase
      end
      // A new press in the same cycle as its clear wins.
      key_edge_d = (key_edge_q & ~edge_clr) | press;
      irq_d      = |(key_edge_q & mask_q);
   end

   always_comb begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
      if (blink_cnt_q >= period_q) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   always_comb begin
      led_d = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         unique case (mode_q[2*i +: 2])
            2'b00: led_d[i] = 1'b0;
            2'b01: led_d[i] = 1'b1;
            2'b10: led_d[i] = phase_q;
            2'b11: led_d[i] = pwm_lit;
         endcase
      end
   end

   always_comb begin
      rdata_d = '0;
      case (avs_address)
         3'd0:    rdata_d[NUM_KEYS-1:0]       = state_q;
         3'd1:    rdata_d[NUM_KEYS-1:0]       = key_edge_q;
         3'd2:    rdata_d[NUM_KEYS-1:0]       = mask_q;
         3'd3:    rdata_d[2*NUM_LEDS-1:0]     = mode_q;
`ifdef BOARD_IO_PWM_EN
         3'd4:    rdata_d[PWM_BITS-1:0]       = duty_q;
`endif
         3'd5:    rdata_d[BLINK_DIV_BITS-1:0] = period_q;
         default: ;
      endcase
      if (!avs_read) rdata_d = rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= '1;
         sync2_q     <= '1;
         state_q     <= '0;
         key_edge_q  <= '0;
         mask_q      <= '0;
         for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
         mode_q      <= '0;
         period_q    <= '1;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         led_q       <= '0;
         irq_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         sync1_q     <= key_n;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         key_edge_q  <= key_edge_d;
         mask_q      <= mask_d;
         for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
         mode_q      <= mode_d;
         period_q    <= period_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         led_q       <= led_d;
         irq_q       <= irq_d;
         rdata_q     <= rdata_d;
      end
   end

   assign avs_readdata = rdata_q;
   assign irq          = irq_q;
   assign led          = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with DEBOUNCE_CYCLES=4. Inputs change and outputs are
// sampled on the falling clock edge; all tasks start and end on a falling edge.
module tb_board_io_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        irq;
   logic [1:0]  key_n;
   logic [3:0]  led;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   board_io_ctrl #(
      .NUM_LEDS        (4),
      .NUM_KEYS        (2),
      .DEBOUNCE_CYCLES (4),
      .PWM_BITS        (8),
      .BLINK_DIV_BITS  (24)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .irq           (irq),
      .key_n         (key_n),
      .led           (led)
   );

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk);
      d           = avs_readdata;
      avs_read    = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [31:0] exp_rd [6];
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
      exp_rd[2] = 32'h0;
      exp_rd[3] = 32'h0;
`ifdef BOARD_IO_PWM_EN
      exp_rd[4] = 32'h80;
`else
      exp_rd[4] = 32'h0;
`endif
      exp_rd[5] = 32'hFF_FFFF;
      total_cnt++;
      if ({avs_readdata, irq, led} !== 37'h0)
         $display("FAIL reset_outputs: got rd=%h irq=%b led=%b want 0", avs_readdata, irq, led);
      else pass_cnt++;
      for (int a = 0; a < 6; a++) begin
         bus_read(3'(a), d);
         total_cnt++;
         if (d !== exp_rd[a]) $display("FAIL reset_reg%0d: got %h want %h", a, d, exp_rd[a]);
         else pass_cnt++;
      end
   endtask

   task automatic test_debounce();
      logic [31:0] d;
      bus_write(3'd2, 32'h1);
      bus_read(3'd2, d);
      total_cnt++;
      if (d !== 32'h1) $display("FAIL mask_rb: got %h want 1", d);
      else pass_cnt++;
      // Bounce: low for 3 cycles only.
      avs_address = 3'd0;
      avs_read    = 1'b1;
      key_n[0]    = 1'b0;
      repeat (3) @(negedge clk);
      key_n[0] = 1'b1;
      repeat (8) @(negedge clk);
      total_cnt++;
      if (avs_readdata !== 32'h0 || irq !== 1'b0)
         $display("FAIL bounce: got state=%h irq=%b want 0 0", avs_readdata, irq);
      else pass_cnt++;
      // Hold: state flips on edge 6, so the read sampled on edge 7 shows it, and irq rises on 7.
      key_n[0] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         total_cnt++;
         if (avs_readdata !== ((k >= 7) ? 32'h1 : 32'h0) || irq !== (k >= 7))
            $display("FAIL debounce_c%0d: got state=%h irq=%b want state=%0d irq=%0d",
                     k, avs_readdata, irq, (k >= 7), (k >= 7));
         else pass_cnt++;
      end
      avs_read = 1'b0;
      bus_read(3'd1, d);
      total_cnt++;
      if (d !== 32'h1) $display("FAIL edge_set: got %h want 1", d);
      else pass_cnt++;
   endtask

   task automatic test_w1c_race();
      logic [31:0] d;
      key_n[1] = 1'b0;
      repeat (5) @(negedge clk);
      // The write lands on edge 6, the same edge key[1] is accepted.
      bus_write(3'd1, 32'h3);
      total_cnt++;
      if (irq !== 1'b1) $display("FAIL irq_hold_w1c: got %b want 1", irq);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL irq_drop_w1c: got %b want 0", irq);
      else pass_cnt++;
      bus_read(3'd1, d);
      total_cnt++;
      if (d !== 32'h2) $display("FAIL w1c_race: got %h want 2", d);
      else pass_cnt++;
      bus_read(3'd0, d);
      total_cnt++;
      if (d !== 32'h3) $display("FAIL state_both: got %h want 3", d);
      else pass_cnt++;
      bus_write(3'd2, 32'h3);
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL irq_mask_lat: got %b want 0", irq);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (irq !== 1'b1) $display("FAIL irq_mask_rise: got %b want 1", irq);
      else pass_cnt++;
      bus_write(3'd1, 32'h2);
      @(negedge clk);
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL irq_clear1: got %b want 0", irq);
      else pass_cnt++;
      // Releases are accepted but set no edge.
      key_n = 2'b11;
      repeat (12) @(negedge clk);
      bus_read(3'd0, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL release_state: got %h want 0", d);
      else pass_cnt++;
      bus_read(3'd1, d);
      total_cnt++;
      if (d !== 32'h0 || irq !== 1'b0)
         $display("FAIL release_edge: got edge=%h irq=%b want 0 0", d, irq);
      else pass_cnt++;
   endtask

   task automatic test_led_static();
      logic [31:0] d;
      bus_write(3'd3, 32'h44);
      total_cnt++;
      if (led !== 4'b0000) $display("FAIL led_latency: got %b want 0000", led);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (led !== 4'b1010) $display("FAIL led_on_off: got %b want 1010", led);
      else pass_cnt++;
      bus_read(3'd3, d);
      total_cnt++;
      if (d !== 32'h44) $display("FAIL mode_rb: got %h want 44", d);
      else pass_cnt++;
   endtask

   task automatic test_blink();
      logic v;
      logic found;
      bus_write(3'd5, 32'h3);
      bus_write(3'd3, 32'h2);
      @(negedge clk);
      v     = led[0];
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (led[0] !== v) found = 1'b1;
      end
      total_cnt++;
      if (!found) $display("FAIL blink_start: got no toggle in 20 cycles want toggle");
      else pass_cnt++;
      v = led[0];
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         total_cnt++;
         if (led[0] !== (((k / 4) % 2 == 1) ? ~v : v))
            $display("FAIL blink4_c%0d: got %b want %b", k, led[0],
                     (((k / 4) % 2 == 1) ? ~v : v));
         else pass_cnt++;
      end
      bus_write(3'd5, 32'h0);
      @(negedge clk);
      v = led[0];
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         total_cnt++;
         if (led[0] !== (v ^ k[0])) $display("FAIL blink0_c%0d: got %b want %b", k, led[0], v ^ k[0]);
         else pass_cnt++;
      end
   endtask

`ifdef BOARD_IO_PWM_EN
   task automatic test_pwm();
      int          lit;
      logic [31:0] d;
      bus_write(3'd4, 32'h40);
      bus_write(3'd3, 32'h3);
      bus_read(3'd4, d);
      total_cnt++;
      if (d !== 32'h40) $display("FAIL duty_rb: got %h want 40", d);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      lit = 0;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if (led[0] === 1'b1) lit++;
      end
      total_cnt++;
      if (lit != 64) $display("FAIL pwm_40: got %0d lit want 64", lit);
      else pass_cnt++;
      bus_write(3'd4, 32'h0);
      repeat (2) @(negedge clk);
      lit = 0;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if (led[0] !== 1'b0) lit++;
      end
      total_cnt++;
      if (lit != 0) $display("FAIL pwm_0: got %0d lit want 0", lit);
      else pass_cnt++;
   endtask
`else
   task automatic test_pwm();
      int          lit;
      logic [31:0] d;
      bus_write(3'd3, 32'h3);
      repeat (2) @(negedge clk);
      lit = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (led[0] === 1'b1) lit++;
      end
      total_cnt++;
      if (lit != 16) $display("FAIL mode3_on: got %0d lit want 16", lit);
      else pass_cnt++;
      bus_write(3'd4, 32'h10);
      bus_read(3'd4, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL duty_absent: got %h want 0", d);
      else pass_cnt++;
   endtask
`endif

   initial begin
      reset         = 1'b1;
      avs_address   = 3'd0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_writedata = 32'h0;
      key_n         = 2'b11;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_debounce();
      test_w1c_race();
      test_led_static();
      test_blink();
      test_pwm();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board I/O controller: an Avalon-MM slave on the Nios system bus that replaces the bare PIO-to-LED and raw-key-to-reset wiring. It drives NUM_LEDS LEDs, each independently off, on, blinking or PWM-dimmed. It also conditions NUM_KEYS active-low push-buttons with a synchroniser and debouncer, plus press-edge capture and a maskable interrupt. It sits in the 100 MHz system clock domain next to the DDR3-backed Nios core.

## Interface
- NUM_LEDS, 4: LED channels, 1..16.
- NUM_KEYS, 2: key inputs, 1..32.
- DEBOUNCE_CYCLES, 2000000: stable cycles required before a key state change is accepted (20 ms at 100 MHz); minimum 1.
- PWM_BITS, 8: PWM counter/duty width, 1..16.
- BLINK_DIV_BITS, 24: blink prescaler width, 1..32.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered
- irq  out  1  key interrupt, level, registered
- key_n  in  NUM_KEYS  raw buttons, low = pressed, asynchronous
- led  out  NUM_LEDS  LED drive, high = lit, registered

## Operation
- Register map (word address; unused addresses and bits read 0, writes to them ignored):
  - 0 KEY_STATE (RO): debounced pressed state, 1 = pressed.
  - 1 KEY_EDGE (W1C): bit set on debounced press.
  - 2 KEY_MASK (RW): irq enables, reset 0.
  - 3 LED_MODE (RW): 2 bits per LED at [2i+1:2i]: 00 off, 01 on, 10 blink, 11 PWM. Reset 0.
  - 4 PWM_DUTY (RW): [PWM_BITS-1:0], shared by all LEDs. Reset 2^(PWM_BITS-1).
  - 5 BLINK_PERIOD (RW): [BLINK_DIV_BITS-1:0]. Reset all ones.
- Key path, per key:
  - The 2-flop synchroniser resets to 1 (released).
  - The debounce counter increments while the synchronised level differs from the debounced state and clears when they match.
  - On the cycle the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the state flips and the counter clears.
  - A flip to pressed sets the KEY_EDGE bit. A flip to released sets nothing.
- KEY_EDGE W1C: writing 1 clears the bit. If a clear and a new press hit the same bit in the same cycle, the set wins.
- irq = |(KEY_EDGE & KEY_MASK).
- PWM: a free-running PWM_BITS counter. A PWM-mode LED is lit when counter < duty.
  - Duty 0: always off.
  - Duty max: lit 2^PWM_BITS-1 of 2^PWM_BITS cycles.
- Blink: the prescaler counts up. When the count ≥ BLINK_PERIOD, it returns to 0 and the shared blink phase toggles.
  - Period 0 toggles the phase every cycle.
  - Writing a smaller period than the current count causes a wrap on the next cycle.
  - The blink phase resets to 0 (dark).
- Reset at any time returns all registers, counters, phase and outputs to reset values on the next clk edge. A key held through reset is reported as a new press once it has been debounced.

## Timing
- Reset values: avs_readdata 0, irq 0, led all 0, KEY_STATE 0.
- Read latency is 1 cycle with no waitrequest. avs_readdata holds its last value when avs_read is low.
- A write takes effect on the clk edge where avs_write is high. A read in the following cycle returns the new value.
- led is registered: 1 cycle after a mode, duty, counter or phase change.
- Key latency: key_n changes during cycle 0, the synchroniser output changes at cycle 2, and KEY_STATE flips at cycle 2+DEBOUNCE_CYCLES. KEY_EDGE sets on that same edge and irq rises 1 cycle later.
- Bounce shorter than DEBOUNCE_CYCLES produces no state change.
- A W1C write clearing the last enabled edge drops irq 1 cycle after the write edge.

## Configuration
- BOARD_IO_PWM_EN:
  - Defined: PWM counter, PWM_DUTY register and mode 11 behave as specified above.
  - Undefined: the PWM counter and duty register are not built, mode 11 behaves as 01 (on), address 4 reads 0, and writes to it are ignored.

## Test plan
- Reset: assert reset for 2 cycles with key_n held all 1. All outputs must be 0, and reading addresses 0..5 must return 0, 0, 0, 0, 0x80, 0xFFFFFF.
- Debounce (DEBOUNCE_CYCLES=4): drive key_n[0] low for 3 cycles, then high. KEY_STATE stays 0. Next, hold it low: KEY_STATE=1 and KEY_EDGE=1 at cycle 6; with KEY_MASK=1, irq=1 at cycle 7.
- W1C race: time a write of 1 to KEY_EDGE to land on the same edge as a new key[1] press. KEY_EDGE[1] must remain 1.
- PWM (BOARD_IO_PWM_EN defined): set LED_MODE=0x3 and duty 0x40. led[0] must be high for exactly 64 of every 256 cycles. With duty 0, led[0] must stay 0.
- Blink: set BLINK_PERIOD=3 and LED_MODE=0x2. led[0] must toggle every 4 cycles.
- Macro undefined: mode 11 must give a constant led=1, and a write of 0x10 to address 4 must read back 0.
